mips_dbus_target: RTL and testbench

- Responder on the MIPS I core data port: 32-bit data address, 4-bit byte write enables, write data, read strobe and read data.
- Serves a word RAM plus a small memory-mapped I/O page.
- The I/O page holds a byte transmit FIFO with a valid/ready output, a free-running timer and a compare-match interrupt flag.
- The core's MEM stage samples read data in the same cycle the address is driven and never stalls, so reads are combinational and writes commit on the clock edge.

---
 rtl/mips_dbus_target.sv | 152 +++++++++++++++
 tb/tb_mips_dbus_target.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mips_dbus_target.sv
// Data-port responder for a MIPS I core: a word RAM plus an I/O page that holds a
// byte TX FIFO, a free-running timer and a sticky compare-match interrupt.
module mips_dbus_target #(
  parameter int          AW      = 12,
  parameter logic [15:0] IO_PAGE = 16'hFFFF,
  parameter int          QW      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] DA,
  input  logic [3:0]  we,
  input  logic [31:0] DO,
  input  logic        re,
  output logic [31:0] DI,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int            DEPTH    = 1 << QW;
  localparam logic [QW:0]   LVL_FULL = (QW+1)'(DEPTH);
  localparam logic [QW:0]   LVL_ONE  = (QW+1)'(1);
  localparam logic [QW-1:0] PTR_ONE  = QW'(1);

  localparam logic [13:0] OFF_TXDATA  = 14'h0;
  localparam logic [13:0] OFF_STATUS  = 14'h1;
  localparam logic [13:0] OFF_TIMER   = 14'h2;
  localparam logic [13:0] OFF_COMPARE = 14'h3;

  logic [31:0]   mem_q [2**AW];
  logic [7:0]    fifo_q [DEPTH];

  logic [QW-1:0] wr_ptr_q, wr_ptr_d;
  logic [QW-1:0] rd_ptr_q, rd_ptr_d;
  logic [QW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;
  logic [31:0]   timer_q, timer_d;
  logic [31:0]   cmp_q, cmp_d;

  logic          io;
  logic [AW-1:0] ram_idx;
  logic [13:0]   io_off;
  logic          empty, full;
  logic          pop, push_req, push_ok;
  logic          status_wr;
  logic          match;
  logic [7:0]    level8;
  logic [31:0]   io_rdata;
  logic          unused_da;

  assign io        = (DA[31:16] == IO_PAGE);
  assign ram_idx   = DA[AW+1:2];
  assign io_off    = DA[15:2];
  assign unused_da = ^DA[1:0];

  assign empty    = (level_q == '0);
  assign full     = (level_q == LVL_FULL);
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign irq      = irq_q;
  assign level8   = 8'(level_q);

  assign pop       = tx_valid && tx_ready;
  assign push_req  = io && (io_off == OFF_TXDATA) && we[0];
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);
  assign status_wr = io && (io_off == OFF_STATUS) && we[0];
  assign match     = (timer_q == cmp_q);

  always_comb begin
    io_rdata = 32'h0;
    if (io) begin
      case (io_off)
        OFF_STATUS:  io_rdata = {16'h0, level8, 4'h0, irq_q, ovf_q, full, empty};
        OFF_TIMER:   io_rdata = timer_q;
        OFF_COMPARE: io_rdata = cmp_q;
        default:     io_rdata = 32'h0;
      endcase
    end
  end

  assign DI = !re ? 32'h0 : (io ? io_rdata : mem_q[ram_idx]);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    irq_d    = irq_q;
    timer_d  = timer_q + 32'd1;
    cmp_d    = cmp_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    if (status_wr && DO[2]) ovf_d = 1'b0;
    if (push_req && !push_ok) ovf_d = 1'b1;

    // Match is evaluated after the clear so a coincident set wins.
    if (status_wr && DO[3]) irq_d = 1'b0;
    if (match) irq_d = 1'b1;

    if (io && (io_off == OFF_TIMER)) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) timer_d[8*i +: 8] = DO[8*i +: 8];
    end
    if (io && (io_off == OFF_COMPARE)) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) cmp_d[8*i +: 8] = DO[8*i +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      timer_q  <= 32'h0;
      cmp_q    <= 32'hFFFF_FFFF;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      timer_q  <= timer_d;
      cmp_q    <= cmp_d;
    end
  end

  // Storage arrays are never cleared; reset only blocks writes.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) fifo_q[wr_ptr_q] <= DO[7:0];
  end

  always_ff @(posedge clock) begin
    if (!reset && !io) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem_q[ram_idx][8*i +: 8] <= DO[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_mips_dbus_target.sv
// Directed bench for mips_dbus_target: RAM lanes/aliasing, FIFO fill/drain, timer/irq, reset.
module tb_mips_dbus_target;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] DA;
  logic [3:0]  we;
  logic [31:0] DO;
  logic        re;
  logic [31:0] DI;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] rdat;

  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0004;
  localparam logic [31:0] A_TMR = 32'hFFFF_0008;
  localparam logic [31:0] A_CMP = 32'hFFFF_000C;

  mips_dbus_target #(.AW(12), .IO_PAGE(16'hFFFF), .QW(3)) dut (
    .clock(clock), .reset(reset), .DA(DA), .we(we), .DO(DO), .re(re), .DI(DI),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .irq(irq)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    DA = a; DO = d; we = w; re = 1'b0;
    tick();
    we = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    DA = a; we = 4'h0; re = 1'b1;
    #1;
    d = DI;
    re = 1'b0;
  endtask

  initial begin
    reset = 1'b1; DA = 32'h0; we = 4'h0; DO = 32'h0; re = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rd(A_CMP, rdat); check("rst_compare", rdat, 32'hFFFF_FFFF);
    rd(A_ST, rdat);  check("rst_status", rdat, 32'h0000_0001);

    // RAM byte lanes and read strobe gating
    wr(32'h100, 32'h1122_3344, 4'hF);
    wr(32'h100, 32'hAA00_0000, 4'h8);
    rd(32'h100, rdat); check("ram_lanes", rdat, 32'hAA22_3344);
    DA = 32'h100; re = 1'b0; #1;
    check("ram_re0", DI, 32'h0);

    wr(32'h4000_0100, 32'h5, 4'hF);
    rd(32'h100, rdat); check("ram_alias", rdat, 32'h5);

    // Same-cycle read and write: old data visible, write lands on the edge
    wr(32'h200, 32'h77, 4'hF);
    DA = 32'h200; DO = 32'h99; we = 4'hF; re = 1'b1; #1;
    check("ram_rw_old", DI, 32'h77);
    tick(); we = 4'h0; re = 1'b0;
    rd(32'h200, rdat); check("ram_rw_new", rdat, 32'h99);

    rd(32'hFFFF_0010, rdat); check("io_unlisted", rdat, 32'h0);
    rd(A_TX, rdat);          check("io_txdata_rd", rdat, 32'h0);

    // FIFO fill with overflow
    for (int i = 1; i <= 9; i++) wr(A_TX, i, 4'h1);
    rd(A_ST, rdat); check("fifo_full_ovf", rdat, 32'h0000_0806);
    check("fifo_head", {24'h0, tx_data}, 32'h01);
    wr(A_ST, 32'h4, 4'h1);
    rd(A_ST, rdat); check("fifo_ovf_clr", rdat, 32'h0000_0802);

    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_valid", {31'h0, tx_valid}, 32'h1);
      check("drain_data", {24'h0, tx_data}, i);
      tick();
    end
    tx_ready = 1'b0;
    check("drain_empty_valid", {31'h0, tx_valid}, 32'h0);
    check("drain_empty_data", {24'h0, tx_data}, 32'h0);
    rd(A_ST, rdat); check("drain_status", rdat, 32'h0000_0001);

    // Push into a full FIFO while the head pops
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h10 + i, 4'h1);
    tx_ready = 1'b1;
    wr(A_TX, 32'h18, 4'h1);
    tx_ready = 1'b0;
    rd(A_ST, rdat); check("full_pushpop_status", rdat, 32'h0000_0802);
    check("full_pushpop_head", {24'h0, tx_data}, 32'h11);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain2_data", {24'h0, tx_data}, 32'h11 + i);
      tick();
    end
    tx_ready = 1'b0;
    rd(A_ST, rdat); check("drain2_status", rdat, 32'h0000_0001);

    // Timer and compare match
    wr(A_TMR, 32'd10, 4'hF);
    wr(A_CMP, 32'd15, 4'hF);
    rd(A_TMR, rdat); check("timer_run", rdat, 32'd11);
    check("irq_before", {31'h0, irq}, 32'h0);
    tick(); tick(); tick(); tick();
    rd(A_TMR, rdat); check("timer_at_cmp", rdat, 32'd15);
    check("irq_at_cmp", {31'h0, irq}, 32'h0);
    tick();
    check("irq_set", {31'h0, irq}, 32'h1);
    wr(A_CMP, 32'd20, 4'hF);
    tick(); tick();
    rd(A_TMR, rdat); check("timer_19", rdat, 32'd19);
    tick();
    wr(A_ST, 32'h8, 4'h1);
    check("irq_set_beats_clr", {31'h0, irq}, 32'h1);
    wr(A_ST, 32'h8, 4'h1);
    check("irq_clr", {31'h0, irq}, 32'h0);

    wr(A_TMR, 32'hFFFF_FFFF, 4'hF);
    rd(A_TMR, rdat); check("timer_max", rdat, 32'hFFFF_FFFF);
    tick();
    rd(A_TMR, rdat); check("timer_wrap", rdat, 32'h0);

    // Reset in the middle of activity
    wr(A_TX, 32'hA1, 4'h1);
    wr(A_TX, 32'hA2, 4'h1);
    wr(A_TX, 32'hA3, 4'h1);
    wr(A_CMP, 32'd5, 4'hF);
    wr(A_TMR, 32'd3, 4'hF);
    tick(); tick(); tick();
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    wr(A_TMR, 32'd1000, 4'hF);
    rd(A_ST, rdat); check("pre_rst_status", rdat, 32'h0000_0308);
    check("pre_rst_head", {24'h0, tx_data}, 32'hA1);

    reset = 1'b1;
    DA = 32'h100; DO = 32'hDEAD_BEEF; we = 4'hF; re = 1'b1; #1;
    check("rst_di_live", DI, 32'h5);
    tick();
    DA = A_TX; DO = 32'h55; we = 4'h1; re = 1'b0;
    tick();
    reset = 1'b0; we = 4'h0;
    check("post_rst_valid", {31'h0, tx_valid}, 32'h0);
    check("post_rst_data", {24'h0, tx_data}, 32'h0);
    check("post_rst_irq", {31'h0, irq}, 32'h0);
    tick();
    rd(A_TMR, rdat);   check("post_rst_timer", rdat, 32'd1);
    rd(A_CMP, rdat);   check("post_rst_compare", rdat, 32'hFFFF_FFFF);
    rd(A_ST, rdat);    check("post_rst_status", rdat, 32'h0000_0001);
    rd(32'h100, rdat); check("post_rst_ram_kept", rdat, 32'h5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
